// File: rtl/socuart.sv
// socuart: memory-mapped 8N1 UART with TX and RX byte FIFOs.
//
// Word addresses: BASE   = RX ready ({31'b0, rx FIFO non-empty})
//                 BASE+1 = TX ready ({31'b0, tx FIFO not full})
//                 BASE+2 = data (read pops RX head, write pushes TX byte)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   addr_b     shared data-bus word address
//   data_b_in  write data, bits [7:0] used
//   data_b_we  write enable, any nonzero value writes
//   data_b     combinational read data, 0 outside the block's addresses
//   strobe_b   high while addr_b selects this block
//   rxd        serial input, asynchronous, idle high
//   txd        serial output from a flop, idle high
module socuart #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BASE       = 65537
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_b,
    input  logic [31:0] data_b_in,
    input  logic [31:0] data_b_we,
    output logic [31:0] data_b,
    output logic        strobe_b,
    input  logic        rxd,
    output logic        txd
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [31:0]   AddrRx   = 32'(BASE);
    localparam logic [31:0]   AddrTx   = 32'(BASE + 1);
    localparam logic [31:0]   AddrData = 32'(BASE + 2);
    localparam logic [15:0]   DivLast  = 16'(CLK_DIV - 1);
    localparam logic [15:0]   HalfLast = 16'(CLK_DIV / 2 - 1);
    localparam logic [PW-1:0] PtrOne   = PW'(1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // Only the low byte of write data is meaningful.
    logic unused_data_hi;
    assign unused_data_hi = ^data_b_in[31:8];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_data, rd_data, rd_seen_q;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0] tx_head, rx_head;

    assign wr_data = (data_b_we != '0) && (addr_b == AddrData);
    assign rd_data = (data_b_we == '0) && (addr_b == AddrData);

    always_comb begin
        strobe_b = 1'b0;
        data_b   = '0;
        case (addr_b)
            AddrRx: begin
                strobe_b = 1'b1;
                data_b   = {31'b0, ~rx_empty};
            end
            AddrTx: begin
                strobe_b = 1'b1;
                data_b   = {31'b0, ~tx_full};
            end
            AddrData: begin
                strobe_b = 1'b1;
                data_b   = {24'b0, rx_empty ? 8'h00 : rx_head};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp_q, tx_rp_q;
    logic          tx_push, tx_pop;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
    // A pop in the same cycle frees the slot being written.
    assign tx_push  = wr_data && (!tx_full || tx_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            tx_mem  <= '{default: '0};
        end else begin
            if (tx_push) begin
                tx_mem[tx_wp_q[AW-1:0]] <= data_b_in[7:0];
                tx_wp_q                 <= tx_wp_q + PtrOne;
            end
            if (tx_pop) begin
                tx_rp_q <= tx_rp_q + PtrOne;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wp_q, rx_rp_q;
    logic          rx_push, rx_push_ok, rx_pop;
    logic [7:0]    rx_shift_q, rx_shift_d;

    assign rx_empty   = (rx_wp_q == rx_rp_q);
    assign rx_full    = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign rx_head    = rx_mem[rx_rp_q[AW-1:0]];
    // One pop per read access: only the first cycle of a BASE+2 read pops.
    assign rx_pop     = rd_data && !rd_seen_q && !rx_empty;
    assign rx_push_ok = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_mem    <= '{default: '0};
            rd_seen_q <= 1'b0;
        end else begin
            rd_seen_q <= rd_data;
            if (rx_push_ok) begin
                rx_mem[rx_wp_q[AW-1:0]] <= rx_shift_q;
                rx_wp_q                 <= rx_wp_q + PtrOne;
            end
            if (rx_pop) begin
                rx_rp_q <= rx_rp_q + PtrOne;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_done;

    assign tx_done = (tx_cnt_q == DivLast);
    assign txd     = txd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TxIdle:  if (!tx_empty) tx_state_d = TxStart;
            TxStart: if (tx_done) tx_state_d = TxData;
            TxData:  if (tx_done && tx_idx_q == 3'd7) tx_state_d = TxStop;
            TxStop:  if (tx_done) tx_state_d = TxIdle;
        endcase
    end

    // txd_d is the value of the line for the next cycle; it is registered.
    always_comb begin
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    txd_d      = 1'b0;
                end
            end
            TxStart: begin
                if (tx_done) begin
                    tx_cnt_d = '0;
                    tx_idx_d = '0;
                    txd_d    = tx_shift_q[0];
                end
            end
            TxData: begin
                if (tx_done) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        txd_d = 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            TxStop: begin
                if (tx_done) tx_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX synchronizer and FSM
    // ------------------------------------------------------------------
    logic        sync1_q, sync2_q, rx_prev_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic        rx_done, rx_half, rx_fall;

    assign rx_done = (rx_cnt_q == DivLast);
    assign rx_half = (rx_cnt_q == HalfLast);
    assign rx_fall = rx_prev_q && !sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RxIdle:  if (rx_fall) rx_state_d = RxStart;
            // A start bit that is high again at mid-point was a glitch.
            RxStart: if (rx_half) rx_state_d = sync2_q ? RxIdle : RxData;
            RxData:  if (rx_done && rx_idx_q == 3'd7) rx_state_d = RxStop;
            RxStop:  if (rx_done) rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            RxIdle: rx_cnt_d = '0;
            RxStart: begin
                if (rx_half) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                end
            end
            RxData: begin
                if (rx_done) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = rx_idx_q + 3'd1;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                end
            end
            RxStop: begin
                if (rx_done) begin
                    rx_cnt_d = '0;
                    // Framing error (stop bit 0) drops the byte.
                    rx_push  = sync2_q;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_socuart.sv
module tb_socuart;

    localparam logic [31:0] A_RX   = 32'd65537;
    localparam logic [31:0] A_TX   = 32'd65538;
    localparam logic [31:0] A_DATA = 32'd65539;

    logic        clk;
    logic        rst;
    logic [31:0] addr_b;
    logic [31:0] data_b_in;
    logic [31:0] data_b_we;
    logic [31:0] data_b;
    logic        strobe_b;
    logic        rxd;
    logic        txd;

    socuart #(
        .CLK_DIV    (16),
        .FIFO_DEPTH (4),
        .BASE       (65537)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr_b    (addr_b),
        .data_b_in (data_b_in),
        .data_b_we (data_b_we),
        .data_b    (data_b),
        .strobe_b  (strobe_b),
        .rxd       (rxd),
        .txd       (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_tx_q [$];
    logic [32:0] exp_rd_q [$];
    string       rd_name_q [$];
    bit          rd_req    = 1'b0;
    bit          tx_mon_en = 1'b1;
    bit          tx_busy   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // ---------------- read scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [32:0] e;
        string nm;
        if (rd_req) begin
            if (exp_rd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_scoreboard: got read with no expectation queued");
            end else begin
                e  = exp_rd_q.pop_front();
                nm = rd_name_q.pop_front();
                chk({nm, "_strobe"}, 32'(strobe_b), 32'(e[32]));
                chk(nm, data_b, e[31:0]);
            end
        end
    end

    // ---------------- TX frame monitor ----------------
    task automatic check_frame();
        logic [7:0] e;
        logic [7:0] got;
        logic       w;
        bit         unexpected;
        int         bad;
        tx_busy    = 1'b1;
        unexpected = 1'b0;
        e          = 8'h00;
        if (exp_tx_q.size() == 0) unexpected = 1'b1;
        else e = exp_tx_q.pop_front();
        bad = 0;
        got = 8'h00;
        for (int k = 0; k < 160; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 16) w = 1'b0;
            else if (k < 144) w = e[(k - 16) / 16];
            else w = 1'b1;
            if (txd !== w) bad++;
            if (k >= 16 && k < 144 && ((k - 16) % 16) == 8) got[(k - 16) / 16] = txd;
        end
        n_checks++;
        if (unexpected || bad != 0 || got !== e) begin
            n_errors++;
            $display("FAIL tx_frame: got byte 0x%0h (%0d wrong bit-cycles, unexpected=%0d) expected 0x%0h",
                     got, bad, unexpected, e);
        end
        tx_busy = 1'b0;
    endtask

    initial begin
        logic prev;
        logic g0, g1;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_mon_en && prev && !txd) begin
                check_frame();
                // Queued bytes must follow after exactly one idle cycle.
                while (exp_tx_q.size() > 0 && tx_mon_en) begin
                    @(negedge clk);
                    g0 = txd;
                    @(negedge clk);
                    g1 = txd;
                    chk("tx_b2b_gap", 32'({g0, g1}), 32'd2);
                    if (g1 != 1'b0) break;
                    check_frame();
                end
            end
            prev = txd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        addr_b    = a;
        data_b_in = {24'h0, d};
        data_b_we = 32'd1;
    endtask

    task automatic bus_idle();
        @(posedge clk);
        #1;
        addr_b    = 32'd0;
        data_b_we = 32'd0;
        data_b_in = 32'd0;
    endtask

    task automatic bus_read(input string nm, input logic [31:0] a, input logic s,
                            input logic [31:0] d);
        @(posedge clk);
        #1;
        addr_b    = a;
        data_b_we = 32'd0;
        exp_rd_q.push_back({s, d});
        rd_name_q.push_back(nm);
        rd_req = 1'b1;
        @(negedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic wait_tx_done(input string nm);
        int t;
        t = 0;
        while ((exp_tx_q.size() != 0 || tx_busy) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout with %0d frames outstanding, expected 0", nm,
                     exp_tx_q.size());
            exp_tx_q.delete();
        end
    endtask

    // Leaves rxd at the stop-bit value, driven just after a clock edge.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1 rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge clk);
            #1 rxd = b[i];
        end
        repeat (16) @(posedge clk);
        #1 rxd = stop;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] bytes5 [5];
        int lows;
        int t;

        rst       = 1'b0;
        rxd       = 1'b1;
        addr_b    = 32'd0;
        data_b_in = 32'd0;
        data_b_we = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 chk("reset_txd", 32'(txd), 32'd1);
        bus_read("reset_rx_ready", A_RX, 1'b1, 32'd0);
        bus_read("reset_tx_ready", A_TX, 1'b1, 32'd1);
        bus_read("reset_data", A_DATA, 1'b1, 32'd0);
        bus_idle();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single TX frame 0x55
        bus_read("tx_ready_before", A_TX, 1'b1, 32'd1);
        exp_tx_q.push_back(8'h55);
        bus_write(A_DATA, 8'h55);
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            repeat (30) @(posedge clk);
            bus_read("tx_ready_during", A_TX, 1'b1, 32'd1);
        end
        bus_idle();
        wait_tx_done("tx_single");

        // Burst of six writes: five sent in order, sixth dropped on full FIFO
        for (int i = 0; i < 5; i++) exp_tx_q.push_back(8'h11 + 8'(i));
        for (int i = 0; i < 6; i++) bus_write(A_DATA, 8'h11 + 8'(i));
        bus_idle();
        bus_read("tx_ready_full", A_TX, 1'b1, 32'd0);
        bus_read("rx_ready_idle", A_RX, 1'b1, 32'd0);
        bus_idle();
        wait_tx_done("tx_burst");
        bus_read("tx_ready_drained", A_TX, 1'b1, 32'd1);
        bus_idle();

        // RX frame 0xA3, read held three cycles pops once
        send_rx(8'hA3, 1'b1);
        repeat (10) @(posedge clk);
        bus_read("rx_ready_after_a3", A_RX, 1'b1, 32'd1);
        bus_read("rx_data_a3", A_DATA, 1'b1, 32'h0000_00A3);
        bus_read("rx_data_held1", A_DATA, 1'b1, 32'd0);
        bus_read("rx_data_held2", A_DATA, 1'b1, 32'd0);
        bus_read("rx_ready_popped", A_RX, 1'b1, 32'd0);
        bus_idle();
        repeat (16) @(posedge clk);

        // 5-cycle glitch is not a start bit
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (40) @(posedge clk);
        bus_read("rx_glitch", A_RX, 1'b1, 32'd0);
        bus_idle();

        // Framing error discards the byte
        send_rx(8'h3C, 1'b0);
        repeat (16) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (20) @(posedge clk);
        bus_read("rx_framing_err", A_RX, 1'b1, 32'd0);
        bus_idle();

        // Five frames without reads: four retained in order, fifth dropped
        bytes5[0] = 8'h01;
        bytes5[1] = 8'h80;
        bytes5[2] = 8'hFF;
        bytes5[3] = 8'h5A;
        bytes5[4] = 8'h77;
        for (int i = 0; i < 5; i++) begin
            send_rx(bytes5[i], 1'b1);
            repeat (16) @(posedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read("rx_fifo_data", A_DATA, 1'b1, {24'h0, bytes5[i]});
            bus_read("rx_fifo_ready", A_RX, 1'b1, (i < 3) ? 32'd1 : 32'd0);
        end
        bus_idle();

        // Reset 40 cycles into a TX frame with more bytes queued
        tx_mon_en = 1'b0;
        bus_write(A_DATA, 8'hF0);
        bus_write(A_DATA, 8'h0F);
        bus_idle();
        t = 0;
        while (txd !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rst_test_frame_start", 32'(txd), 32'd0);
        repeat (40) @(posedge clk);
        #1 chk("pre_rst_txd", 32'(txd), 32'd0);
        rst = 1'b0;
        #1 chk("rst_txd_async", 32'(txd), 32'd1);
        bus_read("rst_rx_ready", A_RX, 1'b1, 32'd0);
        bus_read("rst_tx_ready", A_TX, 1'b1, 32'd1);
        bus_read("rst_data", A_DATA, 1'b1, 32'd0);
        bus_read("addr_65542", 32'd65542, 1'b0, 32'd0);
        bus_read("addr_below_base", 32'd65536, 1'b0, 32'd0);
        bus_idle();
        @(negedge clk);
        rst = 1'b1;
        tx_mon_en = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("no_tx_after_rst", 32'(lows), 32'd0);
        bus_read("post_rst_tx_ready", A_TX, 1'b1, 32'd1);
        bus_read("post_rst_rx_ready", A_RX, 1'b1, 32'd0);
        bus_idle();
        wait_tx_done("tx_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
